// File: rtl/histogram.sv
// rtl/histogram.sv - 256-bin gray-level histogram with clear/accumulate/drain/output sequencing
module histogram #(
  parameter int NPIX = 16384,
  parameter int CW   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [7:0]    din,
  output logic          re,
  output logic          oe,
  output logic [7:0]    hbin,
  output logic [CW-1:0] hout,
  input  logic          ordy,
  output logic          done
);

  localparam int NW = $clog2(NPIX + 1);

  localparam logic [1:0] S_CLR   = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          drn_q, drn_d;
  logic          re_q, re_d;
  logic          oe_q, oe_d;
  logic          done_q, done_d;
  logic [7:0]    hbin_q, hbin_d;
  logic [CW-1:0] hout_q, hout_d;

  logic          s1_v_q, s2_v_q;
  logic [7:0]    s1_a_q, s2_a_q;
  logic [CW-1:0] s2_c_q;
  logic [CW-1:0] bins_q [256];

  logic          accept;
  logic [CW-1:0] s1_rd;
  logic [7:0]    out_a;
  logic [CW-1:0] out_rd;

  assign accept = we && !re_q && (state_q == S_ACC);

  // Reads see the increment still waiting in stage 2, so equal back-to-back samples never lose a count.
  always_comb begin
    s1_rd = (s2_v_q && (s2_a_q == s1_a_q)) ? s2_c_q : bins_q[s1_a_q];
    out_a = (state_q == S_OUT) ? 8'(hbin_q + 8'd1) : 8'd0;
    out_rd = (s2_v_q && (s2_a_q == out_a)) ? s2_c_q : bins_q[out_a];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    re_d    = re_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    hbin_d  = hbin_q;
    hout_d  = hout_q;
    case (state_q)
      S_CLR: begin
        idx_d = 8'(idx_q + 8'd1);
        if (idx_q == 8'd255) begin
          state_d = S_ACC;
          re_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      S_ACC: begin
        if (accept) begin
          cnt_d = NW'(cnt_q + NW'(1));
          if (cnt_q == NW'(NPIX - 1)) begin
            state_d = S_DRAIN;
            re_d    = 1'b1;
            drn_d   = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        drn_d = 1'b1;
        if (drn_q) begin
          state_d = S_OUT;
          oe_d    = 1'b1;
          hbin_d  = 8'd0;
          hout_d  = out_rd;
        end
      end
      default: begin
        if (ordy) begin
          if (hbin_q == 8'd255) begin
            state_d = S_CLR;
            idx_d   = 8'd0;
            oe_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            hbin_d = out_a;
            hout_d = out_rd;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLR;
      idx_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= 1'b0;
      re_q    <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      hbin_q  <= '0;
      hout_q  <= '0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_a_q  <= '0;
      s2_c_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      re_q    <= re_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      hbin_q  <= hbin_d;
      hout_q  <= hout_d;
      s1_v_q  <= accept;
      s1_a_q  <= din;
      s2_v_q  <= s1_v_q;
      s2_a_q  <= s1_a_q;
      s2_c_q  <= CW'(s1_rd + CW'(1));
    end
  end

  // Bin storage has no reset; the CLR sweep zeroes it before every frame.
  always_ff @(posedge clk) begin
    if (state_q == S_CLR) begin
      bins_q[idx_q] <= '0;
    end else if (s2_v_q) begin
      bins_q[s2_a_q] <= s2_c_q;
    end
  end

  assign re   = re_q;
  assign oe   = oe_q;
  assign done = done_q;
  assign hbin = hbin_q;
  assign hout = hout_q;

endmodule

// File: tb/tb_histogram.sv
// tb/tb_histogram.sv - scoreboard bench for histogram (small frame plus full-size frame)
module tb_histogram;

  localparam int NPIX = 16;
  localparam int CW   = 5;
  localparam int BNPIX = 16384;
  localparam int BCW   = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, ordy;
  logic [7:0]    din;
  logic          re, oe, done;
  logic [7:0]    hbin;
  logic [CW-1:0] hout;

  logic           we_b, ordy_b;
  logic [7:0]     din_b;
  logic           re_b, oe_b, done_b;
  logic [7:0]     hbin_b;
  logic [BCW-1:0] hout_b;

  int tests = 0;
  int fails = 0;
  int model [256];
  int exp_bin [$];
  int exp_cnt [$];

  always #5 clk = ~clk;

  histogram #(.NPIX(NPIX), .CW(CW)) dut (
    .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .oe(oe),
    .hbin(hbin), .hout(hout), .ordy(ordy), .done(done)
  );

  histogram #(.NPIX(BNPIX), .CW(BCW)) dut_big (
    .clk(clk), .rst(rst), .we(we_b), .din(din_b), .re(re_b), .oe(oe_b),
    .hbin(hbin_b), .hout(hout_b), .ordy(ordy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < 256; b++) model[b] = 0;
  endtask

  // Counts CLR cycles from the current negedge until re falls.
  task automatic clr_check();
    int n = 0;
    int bad = 0;
    while (re === 1'b1 && n < 1000) begin
      if (oe !== 1'b0 || done !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    check("clr_len", n, 256);
    check("clr_oe_done", bad, 0);
  endtask

  task automatic send_sample(input logic [7:0] d);
    int g = 0;
    while (re !== 1'b0 && g < 400) begin
      g++;
      @(negedge clk);
    end
    if (g >= 400) check("send_timeout", g, 0);
    we  = 1'b1;
    din = d;
    model[d]++;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Called at the negedge right after the last accepted sample.
  task automatic collect(input int stall_bin, input int stall_n);
    int sum = 0;
    int stalled = 0;
    int guard = 0;
    for (int b = 0; b < 256; b++) begin
      exp_bin.push_back(b);
      exp_cnt.push_back(model[b]);
    end
    we = 1'b1;
    check("full_re", re, 1);
    check("drain1_oe", oe, 0);
    @(negedge clk);
    check("drain2_oe", oe, 0);
    check("drain2_re", re, 1);
    @(negedge clk);
    we = 1'b0;
    check("out_oe", oe, 1);
    while (exp_bin.size() > 0 && guard < 2000) begin
      guard++;
      check("out_hbin", hbin, exp_bin[0]);
      check("out_hout", hout, exp_cnt[0]);
      if (exp_bin[0] == stall_bin && stalled < stall_n) begin
        ordy = 1'b0;
        stalled++;
      end else begin
        ordy = 1'b1;
        sum += exp_cnt[0];
        void'(exp_bin.pop_front());
        void'(exp_cnt.pop_front());
      end
      @(negedge clk);
    end
    check("out_remaining", exp_bin.size(), 0);
    check("done_pulse", done, 1);
    check("done_oe", oe, 0);
    check("out_sum", sum, NPIX);
    @(negedge clk);
    check("done_once", done, 0);
    check("clr_re", re, 1);
    clear_model();
  endtask

  initial begin
    int g;
    int bad;
    int bsum;
    rst = 1'b0; we = 1'b0; din = 8'd0; ordy = 1'b1;
    we_b = 1'b0; din_b = 8'd0; ordy_b = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_re", re, 1);
    check("rst_oe", oe, 0);
    check("rst_done", done, 0);
    check("rst_hbin", hbin, 0);
    check("rst_hout", hout, 0);
    rst = 1'b1;
    clr_check();

    for (int i = 0; i < NPIX; i++) send_sample(8'h05);
    collect(-1, 0);

    for (int i = 0; i < NPIX; i++) begin
      send_sample(8'(i));
      if (i != NPIX - 1) @(negedge clk);
    end
    collect(3, 5);

    for (int i = 0; i < 7; i++) send_sample(8'(i * 3));
    rst = 1'b0;
    #1;
    check("async_rst_re", re, 1);
    check("async_rst_oe", oe, 0);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    clr_check();
    for (int i = 0; i < NPIX; i++) send_sample(8'hFF);
    collect(-1, 0);

    g = 0;
    while (re_b !== 1'b0 && g < 400) begin
      g++;
      @(negedge clk);
    end
    check("big_ready", re_b, 0);
    bad = 0;
    we_b = 1'b1;
    din_b = 8'h80;
    for (int i = 0; i < BNPIX; i++) begin
      if (re_b !== 1'b0) bad++;
      @(negedge clk);
    end
    we_b = 1'b0;
    check("big_stall", bad, 0);
    check("big_full_re", re_b, 1);
    g = 0;
    while (oe_b !== 1'b1 && g < 10) begin
      g++;
      @(negedge clk);
    end
    check("big_drain", g, 2);
    ordy_b = 1'b1;
    bsum = 0;
    for (int b = 0; b < 256; b++) begin
      check("big_hbin", hbin_b, b);
      check("big_hout", hout_b, (b == 128) ? BNPIX : 0);
      bsum += int'(hout_b);
      @(negedge clk);
    end
    check("big_sum", bsum, BNPIX);
    check("big_done", done_b, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
